bcd_lap_timer: RTL and testbench

BCD_LAP_TIMER -- requirements
Module: bcd_lap_timer

---
 rtl/bcd_timer_pkg.sv | 22 ++
 rtl/bcd_digit.sv | 41 ++++
 rtl/bcd_lap_timer.sv | 134 +++++++++++++
 tb/tb_bcd_lap_timer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD lap timer.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t  MAX_DIGIT  = 4'd9;
  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned MAX_SPEEDS = 8;

  // Clamp a non-decimal nibble to 9.
  function automatic bcd_digit_t sat_digit(input bcd_digit_t d);
    return (d > MAX_DIGIT) ? MAX_DIGIT : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: clear, saturating load, up/down step with ripple carry/borrow.
module bcd_digit
  import bcd_timer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       dir_i,
  input  logic       ld_i,
  input  bcd_digit_t ld_val_i,
  input  logic       cin_i,
  output bcd_digit_t val_o,
  output logic       cout_o
);

  bcd_digit_t val_q, val_d;

  // Next digit value: clear > load > step.
  always_comb begin
    val_d = val_q;
    if (clr_i) begin
      val_d = '0;
    end else if (ld_i) begin
      val_d = sat_digit(ld_val_i);
    end else if (en_i && cin_i) begin
      if (dir_i) val_d = (val_q == 4'd0)      ? MAX_DIGIT : val_q - 4'd1;
      else       val_d = (val_q >= MAX_DIGIT) ? 4'd0      : val_q + 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) val_q <= '0;
    else         val_q <= val_d;
  end

  assign val_o  = val_q;
  assign cout_o = cin_i & (dir_i ? (val_q == 4'd0) : (val_q == MAX_DIGIT));

endmodule

// File: rtl/bcd_lap_timer.sv
// BCD lap timer: run/pause/done control, speed-selectable prescaler,
// NUM_DIGITS cascaded BCD decades. Lap register present only when
// BCD_LAP_TIMER_LAP_EN is defined; otherwise lap_bcd is tied to zero.
module bcd_lap_timer
  import bcd_timer_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned TICK_DIV   = 1000000,
  parameter int unsigned NUM_SPEEDS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    speed_btn,
  input  logic                    pause_btn,
  input  logic                    clear,
  input  logic                    lap,
  input  logic                    dir,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_bcd,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic [4*NUM_DIGITS-1:0] lap_bcd,
  output logic [2:0]              speed_sel,
  output logic                    running,
  output logic                    wrap,
  output logic                    done
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [2:0]      speed_q, speed_d;
  logic            wrap_q, wrap_d;
  logic            step, ld_en;
  logic [31:0]     term;
  logic            tick;
  logic            is_zero, is_one;
  logic [NUM_DIGITS:0] carry;

  assign term    = (32'(TICK_DIV) >> speed_q) - 32'd1;
  assign tick    = (32'(presc_q) == term);
  assign is_zero = (count_bcd == '0);
  assign is_one  = (count_bcd == (4*NUM_DIGITS)'(1));
  assign carry[0] = 1'b1;

  // Decade chain; carry/borrow ripples combinationally within one step.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .clr_i    (clear),
      .en_i     (step),
      .dir_i    (dir),
      .ld_i     (ld_en),
      .ld_val_i (load_bcd[4*g +: 4]),
      .cin_i    (carry[g]),
      .val_o    (count_bcd[4*g +: 4]),
      .cout_o   (carry[g+1])
    );
  end

  // Control: next state, prescaler, step/load strobes, wrap pulse.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    speed_d = speed_q;
    wrap_d  = 1'b0;
    step    = 1'b0;
    ld_en   = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end else if (load && (state_q == ST_IDLE || state_q == ST_PAUSE)) begin
      ld_en = 1'b1;
    end else if (pause_btn && state_q != ST_DONE) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
    end else if (state_q == ST_RUN) begin
      if (tick) begin
        presc_d = '0;
        // A down-step from zero only terminates; the count is left alone.
        if (dir && is_zero) begin
          state_d = ST_DONE;
        end else begin
          step = 1'b1;
          if (dir && is_one)            state_d = ST_DONE;
          if (!dir && carry[NUM_DIGITS]) wrap_d = 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    if (speed_btn) begin
      speed_d = (speed_q == 3'(NUM_SPEEDS - 1)) ? 3'd0 : speed_q + 3'd1;
      presc_d = '0;
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      speed_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      speed_q <= speed_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef BCD_LAP_TIMER_LAP_EN
  logic [4*NUM_DIGITS-1:0] lap_q;

  // Lap capture of the registered (pre-step) count, in any state.
  always_ff @(posedge clk) begin
    if (!rst_n)   lap_q <= '0;
    else if (lap) lap_q <= count_bcd;
  end

  assign lap_bcd = lap_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_bcd    = '0;
`endif

  assign speed_sel = speed_q;
  assign running   = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_bcd_lap_timer.sv
// Directed self-checking bench for bcd_lap_timer (4 digits, TICK_DIV 16, 5 speeds).
module tb_bcd_lap_timer;

  logic        clk = 1'b0;
  logic        rst_n, speed_btn, pause_btn, clear, lap, dir, load;
  logic [15:0] load_bcd, count_bcd, lap_bcd;
  logic [2:0]  speed_sel;
  logic        running, wrap, done;
  int          tests = 0;
  int          fails = 0;

  bcd_lap_timer #(.NUM_DIGITS(4), .TICK_DIV(16), .NUM_SPEEDS(5)) dut (
    .clk(clk), .rst_n(rst_n), .speed_btn(speed_btn), .pause_btn(pause_btn),
    .clear(clear), .lap(lap), .dir(dir), .load(load), .load_bcd(load_bcd),
    .count_bcd(count_bcd), .lap_bcd(lap_bcd), .speed_sel(speed_sel),
    .running(running), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

`ifdef BCD_LAP_TIMER_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_pause();  pause_btn = 1'b1; cyc(); pause_btn = 1'b0; endtask
  task automatic pulse_speed();  speed_btn = 1'b1; cyc(); speed_btn = 1'b0; endtask
  task automatic pulse_clear();  clear     = 1'b1; cyc(); clear     = 1'b0; endtask
  task automatic pulse_load(input logic [15:0] v);
    load_bcd = v; load = 1'b1; cyc(); load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; speed_btn = 0; pause_btn = 0; clear = 0; lap = 0; dir = 0;
    load = 0; load_bcd = '0;
    cyc(2);
    tests++;
    if ({count_bcd, lap_bcd, speed_sel, running, wrap, done} !== 38'd0) begin
      fails++;
      $display("FAIL reset outputs: count=%h lap=%h speed=%0d run=%b wrap=%b done=%b, want all zero",
               count_bcd, lap_bcd, speed_sel, running, wrap, done);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_count_up();
    pulse_pause();
    tests++;
    if (running !== 1'b1) begin fails++; $display("FAIL start running=%b want 1", running); end
    cyc(159);
    tests++;
    if (count_bcd !== 16'h0009) begin fails++; $display("FAIL up159 count=%h want 0009", count_bcd); end
    cyc();
    tests++;
    if (count_bcd !== 16'h0010 || running !== 1'b1) begin
      fails++; $display("FAIL up160 count=%h run=%b want 0010/1", count_bcd, running);
    end
  endtask

  task automatic test_speed();
    repeat (4) pulse_speed();
    tests++;
    if (speed_sel !== 3'd4 || count_bcd !== 16'h0010) begin
      fails++; $display("FAIL speed4 speed=%0d count=%h want 4/0010", speed_sel, count_bcd);
    end
    cyc();
    tests++;
    if (count_bcd !== 16'h0011) begin fails++; $display("FAIL speed4 step1 count=%h want 0011", count_bcd); end
    cyc();
    tests++;
    if (count_bcd !== 16'h0012) begin fails++; $display("FAIL speed4 step2 count=%h want 0012", count_bcd); end
    pulse_speed();  // steps once more at speed 4, then back to speed 0
    tests++;
    if (speed_sel !== 3'd0 || count_bcd !== 16'h0013) begin
      fails++; $display("FAIL speed wrap speed=%0d count=%h want 0/0013", speed_sel, count_bcd);
    end
    cyc(15);
    tests++;
    if (count_bcd !== 16'h0013) begin fails++; $display("FAIL presc zeroed 15 count=%h want 0013", count_bcd); end
    cyc();
    tests++;
    if (count_bcd !== 16'h0014) begin fails++; $display("FAIL presc zeroed 16 count=%h want 0014", count_bcd); end
  endtask

  task automatic test_wrap();
    pulse_pause();
    pulse_load(16'h9998);
    tests++;
    if (count_bcd !== 16'h9998 || running !== 1'b0) begin
      fails++; $display("FAIL pause load count=%h run=%b want 9998/0", count_bcd, running);
    end
    repeat (4) pulse_speed();
    pulse_pause();
    tests++;
    if (count_bcd !== 16'h9998 || running !== 1'b1 || speed_sel !== 3'd4) begin
      fails++; $display("FAIL resume count=%h run=%b speed=%0d want 9998/1/4", count_bcd, running, speed_sel);
    end
    cyc();
    tests++;
    if (count_bcd !== 16'h9999 || wrap !== 1'b0) begin
      fails++; $display("FAIL pre-wrap count=%h wrap=%b want 9999/0", count_bcd, wrap);
    end
    cyc();
    tests++;
    if (count_bcd !== 16'h0000 || wrap !== 1'b1 || running !== 1'b1) begin
      fails++; $display("FAIL wrap count=%h wrap=%b run=%b want 0000/1/1", count_bcd, wrap, running);
    end
    cyc();
    tests++;
    if (count_bcd !== 16'h0001 || wrap !== 1'b0) begin
      fails++; $display("FAIL post-wrap count=%h wrap=%b want 0001/0", count_bcd, wrap);
    end
    pulse_load(16'h5555);  // ignored while running
    tests++;
    if (count_bcd !== 16'h0002) begin fails++; $display("FAIL load in run count=%h want 0002", count_bcd); end
    pulse_pause();
    tests++;
    if (count_bcd !== 16'h0002 || running !== 1'b0) begin
      fails++; $display("FAIL pause over step count=%h run=%b want 0002/0", count_bcd, running);
    end
    pulse_load(16'hAF3B);
    tests++;
    if (count_bcd !== 16'h9939) begin fails++; $display("FAIL saturate count=%h want 9939", count_bcd); end
  endtask

  task automatic test_count_down();
    dir = 1'b1;
    pulse_load(16'h0003);
    pulse_pause();
    cyc();
    tests++;
    if (count_bcd !== 16'h0002) begin fails++; $display("FAIL down1 count=%h want 0002", count_bcd); end
    cyc();
    tests++;
    if (count_bcd !== 16'h0001 || done !== 1'b0) begin
      fails++; $display("FAIL down2 count=%h done=%b want 0001/0", count_bcd, done);
    end
    cyc();
    tests++;
    if (count_bcd !== 16'h0000 || done !== 1'b1 || running !== 1'b0) begin
      fails++; $display("FAIL done count=%h done=%b run=%b want 0000/1/0", count_bcd, done, running);
    end
    pulse_pause();
    cyc(2);
    tests++;
    if (done !== 1'b1 || running !== 1'b0 || count_bcd !== 16'h0000) begin
      fails++; $display("FAIL done pause done=%b run=%b count=%h want 1/0/0000", done, running, count_bcd);
    end
    pulse_clear();
    tests++;
    if (done !== 1'b0 || running !== 1'b0 || count_bcd !== 16'h0000 || speed_sel !== 3'd4) begin
      fails++; $display("FAIL done clear done=%b run=%b count=%h speed=%0d want 0/0/0000/4",
                        done, running, count_bcd, speed_sel);
    end
    pulse_pause();
    tests++;
    if (running !== 1'b1) begin fails++; $display("FAIL run at zero running=%b want 1", running); end
    cyc();
    tests++;
    if (done !== 1'b1 || count_bcd !== 16'h0000) begin
      fails++; $display("FAIL down from zero done=%b count=%h want 1/0000", done, count_bcd);
    end
    pulse_clear();
    dir = 1'b0;
  endtask

  task automatic test_lap_clear();
    pulse_load(16'h0042);
    tests++;
    if (count_bcd !== 16'h0042) begin fails++; $display("FAIL idle load count=%h want 0042", count_bcd); end
    lap = 1'b1; clear = 1'b1;
    cyc();
    lap = 1'b0; clear = 1'b0;
    tests++;
    if (lap_bcd !== (LAP_EN ? 16'h0042 : 16'h0000) || count_bcd !== 16'h0000 || running !== 1'b0) begin
      fails++; $display("FAIL lap+clear lap=%h count=%h run=%b want %h/0000/0",
                        lap_bcd, count_bcd, running, LAP_EN ? 16'h0042 : 16'h0000);
    end
    pulse_pause();
    cyc(2);
    lap = 1'b1;
    cyc();
    lap = 1'b0;
    tests++;
    if (lap_bcd !== (LAP_EN ? 16'h0002 : 16'h0000) || count_bcd !== 16'h0003) begin
      fails++; $display("FAIL lap pre-step lap=%h count=%h want %h/0003",
                        lap_bcd, count_bcd, LAP_EN ? 16'h0002 : 16'h0000);
    end
    pulse_clear();
  endtask

  task automatic test_reset_mid();
    pulse_load(16'h0120);
    repeat (3) pulse_speed();
    pulse_pause();
    cyc(12);
    tests++;
    if (count_bcd !== 16'h0123 || speed_sel !== 3'd2 || running !== 1'b1) begin
      fails++; $display("FAIL speed2 run count=%h speed=%0d run=%b want 0123/2/1", count_bcd, speed_sel, running);
    end
    rst_n = 1'b0; pause_btn = 1'b1; load = 1'b1; load_bcd = 16'h7777;
    cyc();
    tests++;
    if ({count_bcd, lap_bcd, speed_sel, running, wrap, done} !== 38'd0) begin
      fails++; $display("FAIL mid reset count=%h lap=%h speed=%0d run=%b wrap=%b done=%b, want all zero",
                        count_bcd, lap_bcd, speed_sel, running, wrap, done);
    end
    rst_n = 1'b1; pause_btn = 1'b0; load = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_speed();
    test_wrap();
    test_count_down();
    test_lap_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
